// File: rtl/nanorv32_irq_ctrl.sv
// Interrupt controller: edge-latched pending bits, per-source and global masking,
// one lowest-index request at a time with ack / reti handshake and a 4-word config port.
//
// state  | meaning
// IDLE   | no request, nothing in service
// REQ    | irq asserted, irq_id frozen, waiting for irq_ack
// ACTIVE | handler in service, waiting for reti_inst_detected
module nanorv32_irq_ctrl #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_src,
    output logic               irq,
    output logic [4:0]         irq_id,
    input  logic               irq_ack,
    input  logic               reti_inst_detected,
    input  logic               cfg_wr,
    input  logic [1:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] sync1_q, sync2_q, prev_q;
    logic [NUM_IRQ-1:0] en_q, en_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic               gie_q, gie_d;
    logic               irq_q, irq_d;
    logic [4:0]         irq_id_q, irq_id_d;
    logic [NUM_IRQ-1:0] src_edge;
    logic [NUM_IRQ-1:0] req_vec;
    logic [4:0]         sel_id;
    logic               ack_take;
    logic               unused_wdata;

    assign unused_wdata = ^cfg_wdata;

    assign src_edge = sync2_q & ~prev_q;
    assign req_vec  = pend_q & en_q;
    assign ack_take = (state_q == REQ) && irq_ack;
    assign irq      = irq_q;
    assign irq_id   = irq_id_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            en_q     <= '0;
            pend_q   <= '0;
            gie_q    <= 1'b0;
            state_q  <= IDLE;
            irq_q    <= 1'b0;
            irq_id_q <= '0;
        end else begin
            sync1_q  <= irq_src;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            en_q     <= en_d;
            pend_q   <= pend_d;
            gie_q    <= gie_d;
            state_q  <= state_d;
            irq_q    <= irq_d;
            irq_id_q <= irq_id_d;
        end
    end

    always_comb begin
        sel_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req_vec[i]) sel_id = 5'(i);
        end
    end

    // Config register writes; a fresh edge beats both ack-clear and W1C.
    always_comb begin
        en_d   = en_q;
        gie_d  = gie_q;
        pend_d = pend_q;
        if (cfg_wr && cfg_addr == 2'd0) en_d = cfg_wdata[NUM_IRQ-1:0];
        if (cfg_wr && cfg_addr == 2'd2) gie_d = cfg_wdata[0];
        if (cfg_wr && cfg_addr == 2'd1) pend_d = pend_d & ~cfg_wdata[NUM_IRQ-1:0];
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (ack_take && irq_id_q == 5'(i)) pend_d[i] = 1'b0;
        end
        pend_d = pend_d | src_edge;
    end

    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        case (state_q)
            IDLE: begin
                if (gie_q && |req_vec) begin
                    state_d  = REQ;
                    irq_id_d = sel_id;
                end
            end
            REQ: begin
                if (irq_ack)     state_d = ACTIVE;
                else if (!gie_q) state_d = IDLE;
            end
            ACTIVE: begin
                if (reti_inst_detected) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        irq_d = (state_d == REQ);
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            2'd0: cfg_rdata[NUM_IRQ-1:0] = en_q;
            2'd1: cfg_rdata[NUM_IRQ-1:0] = pend_q;
            2'd2: cfg_rdata[1:0] = {state_q == ACTIVE, gie_q};
            default: begin
                cfg_rdata[4:0] = irq_id_q;
                cfg_rdata[8]   = irq_q;
            end
        endcase
    end

endmodule

// File: tb/tb_nanorv32_irq_ctrl.sv
// Directed bench for nanorv32_irq_ctrl: handshake, priority, masking, collisions,
// reset behaviour and ignored strobes, all against hand-computed values.
module tb_nanorv32_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  irq_src = '0;
    logic        irq;
    logic [4:0]  irq_id;
    logic        irq_ack = 1'b0;
    logic        reti_inst_detected = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic [31:0] cfg_rdata;

    int n_vec = 0;
    int n_err = 0;

    nanorv32_irq_ctrl #(.NUM_IRQ(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .irq_src            (irq_src),
        .irq                (irq),
        .irq_id             (irq_id),
        .irq_ack            (irq_ack),
        .reti_inst_detected (reti_inst_detected),
        .cfg_wr             (cfg_wr),
        .cfg_addr           (cfg_addr),
        .cfg_wdata          (cfg_wdata),
        .cfg_rdata          (cfg_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_wr    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_wr    = 1'b0;
        cfg_wdata = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic pulse_reti();
        reti_inst_detected = 1'b1;
        tick();
        reti_inst_detected = 1'b0;
    endtask

    logic [31:0] r;

    initial begin
        tick(3);
        rst = 1'b0;
        tick();
        check_val("rst_irq", {31'd0, irq}, 32'd0);
        check_val("rst_id", {27'd0, irq_id}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), r);
            check_val("rst_rdata", r, 32'd0);
        end

        // basic handshake on source 2
        cfg_write(2'd0, 32'h04);
        cfg_write(2'd2, 32'h01);
        irq_src[2] = 1'b1;
        tick();
        irq_src[2] = 1'b0;
        tick(2);
        check_val("lat_irq_e2", {31'd0, irq}, 32'd0);
        rd(2'd1, r);
        check_val("lat_pend_e2", r, 32'h04);
        tick();
        check_val("lat_irq_e3", {31'd0, irq}, 32'd1);
        check_val("lat_id", {27'd0, irq_id}, 32'd2);
        pulse_ack();
        check_val("ack_irq", {31'd0, irq}, 32'd0);
        rd(2'd1, r);
        check_val("ack_pend", r, 32'h00);
        rd(2'd2, r);
        check_val("ack_ctrl", r, 32'h03);
        rd(2'd3, r);
        check_val("ack_status", r, 32'h02);
        pulse_ack();
        rd(2'd2, r);
        check_val("ack_in_active", r, 32'h03);
        pulse_reti();
        rd(2'd2, r);
        check_val("reti_ctrl", r, 32'h01);
        tick(2);
        check_val("reti_irq", {31'd0, irq}, 32'd0);
        pulse_ack();
        rd(2'd2, r);
        check_val("ack_in_idle", r, 32'h01);

        // priority: 3 before 5
        cfg_write(2'd0, 32'hFF);
        irq_src = 8'h28;
        tick(4);
        check_val("prio_irq", {31'd0, irq}, 32'd1);
        check_val("prio_id1", {27'd0, irq_id}, 32'd3);
        rd(2'd1, r);
        check_val("prio_pend", r, 32'h28);
        pulse_reti();
        check_val("reti_in_req_irq", {31'd0, irq}, 32'd1);
        check_val("reti_in_req_id", {27'd0, irq_id}, 32'd3);
        pulse_ack();
        rd(2'd1, r);
        check_val("prio_pend2", r, 32'h20);
        pulse_reti();
        check_val("gap_irq", {31'd0, irq}, 32'd0);
        tick();
        check_val("prio_irq2", {31'd0, irq}, 32'd1);
        check_val("prio_id2", {27'd0, irq_id}, 32'd5);
        pulse_ack();
        pulse_reti();
        rd(2'd1, r);
        check_val("prio_pend_end", r, 32'h00);
        irq_src = 8'h00;

        // masking, non-withdraw on enable clear, withdraw on GIE clear
        cfg_write(2'd0, 32'h00);
        irq_src[1] = 1'b1;
        tick();
        irq_src[1] = 1'b0;
        tick(5);
        rd(2'd1, r);
        check_val("mask_pend", r, 32'h02);
        check_val("mask_irq", {31'd0, irq}, 32'd0);
        cfg_write(2'd0, 32'h02);
        tick();
        check_val("unmask_irq", {31'd0, irq}, 32'd1);
        check_val("unmask_id", {27'd0, irq_id}, 32'd1);
        cfg_write(2'd0, 32'h00);
        tick();
        check_val("en_clear_keeps", {31'd0, irq}, 32'd1);
        cfg_write(2'd2, 32'h00);
        tick();
        check_val("gie_withdraw", {31'd0, irq}, 32'd0);
        rd(2'd1, r);
        check_val("gie_pend_kept", r, 32'h02);
        cfg_write(2'd1, 32'h02);
        rd(2'd1, r);
        check_val("w1c_pend", r, 32'h00);

        // ack colliding with a new edge of the same source
        cfg_write(2'd0, 32'h01);
        cfg_write(2'd2, 32'h01);
        irq_src[0] = 1'b1;
        tick();
        irq_src[0] = 1'b0;
        tick(3);
        check_val("col_irq", {31'd0, irq}, 32'd1);
        check_val("col_id", {27'd0, irq_id}, 32'd0);
        irq_src[0] = 1'b1;
        tick(2);
        pulse_ack();
        irq_src[0] = 1'b0;
        rd(2'd1, r);
        check_val("col_pend", r, 32'h01);
        rd(2'd2, r);
        check_val("col_ctrl", r, 32'h03);
        pulse_reti();
        tick();
        check_val("col_rereq", {31'd0, irq}, 32'd1);
        check_val("col_rereq_id", {27'd0, irq_id}, 32'd0);
        pulse_ack();
        pulse_reti();

        // W1C colliding with an edge
        cfg_write(2'd2, 32'h00);
        irq_src[4] = 1'b1;
        tick(2);
        cfg_write(2'd1, 32'h10);
        rd(2'd1, r);
        check_val("w1c_col", r, 32'h10);
        cfg_write(2'd1, 32'h10);
        rd(2'd1, r);
        check_val("w1c_after", r, 32'h00);
        irq_src[4] = 1'b0;

        // async reset mid-request, source held through release
        cfg_write(2'd0, 32'h80);
        cfg_write(2'd2, 32'h01);
        irq_src[7] = 1'b1;
        tick(4);
        check_val("pre_rst_irq", {31'd0, irq}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_irq", {31'd0, irq}, 32'd0);
        cfg_addr = 2'd0;
        #1;
        check_val("arst_en", cfg_rdata, 32'd0);
        cfg_addr = 2'd3;
        #1;
        check_val("arst_status", cfg_rdata, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(4);
        rd(2'd1, r);
        check_val("rel_pend", r, 32'h80);
        cfg_write(2'd1, 32'h80);
        tick(6);
        rd(2'd1, r);
        check_val("rel_one_event", r, 32'h00);
        check_val("rel_irq", {31'd0, irq}, 32'd0);
        irq_src[7] = 1'b0;

        cfg_write(2'd0, 32'hFFFF_FFFF);
        rd(2'd0, r);
        check_val("en_width", r, 32'h0000_00FF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nanorv32_irq_ctrl.md
# nanorv32_irq_ctrl

Interrupt controller feeding the pipeline flow controller. It latches external interrupt sources as edge-triggered pending bits and masks them with per-source and global enables. It presents one request at a time (lowest index wins) on `irq`, completes the handshake on `irq_ack`, and holds the in-service state until the return-from-interrupt instruction retires. It also exposes a small word-addressed configuration port for the CPU.

## Interface

Parameters:
- `NUM_IRQ`, default 8: number of interrupt sources, legal range 1..32.

Ports:
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `irq_src` in NUM_IRQ: raw asynchronous interrupt lines; rising edge = event.
- `irq` out 1: request to the flow controller; registered.
- `irq_id` out 5: index of the requested or in-service source; registered.
- `irq_ack` in 1: single-cycle pulse from the flow controller accepting the request.
- `reti_inst_detected` in 1: return-from-interrupt instruction retired.
- `cfg_wr` in 1: configuration write strobe.
- `cfg_addr` in 2: word address.
- `cfg_wdata` in 32: write data.
- `cfg_rdata` out 32: combinational read data for `cfg_addr`.

## Operation

- **Synchronizer.** Three flops per source: `sync1`, `sync2`, `prev`. `edge = sync2 & ~prev`. All reset to 0, so a line already high at reset release produces one event.
- **Registers.** Bits ≥ NUM_IRQ read 0 and ignore writes.
  - addr 0, ENABLE: R/W, reset 0.
  - addr 1, PENDING: read; write-1-to-clear; reset 0.
  - addr 2, CTRL: bit0 = GIE (global enable), R/W, reset 0; bit1 = in-service flag, read-only.
  - addr 3, STATUS: bits[4:0] = `irq_id`, bit8 = `irq`, read-only.
- **Pending update priority per bit.** Set by `edge` wins over both clear-by-ack and write-1-to-clear in the same cycle.
- **FSM.**
  - IDLE (`irq`=0): if GIE and `|(PENDING & ENABLE)`, go to REQ and load `irq_id` = lowest set index of `PENDING & ENABLE`.
  - REQ (`irq`=1, `irq_id` frozen):
    - `irq_ack`: clear `PENDING[irq_id]`, go to ACTIVE.
    - Else if GIE=0: withdraw and go to IDLE; the pending bit is kept.
    - A disable of the individual enable or a software clear of the pending bit does not withdraw the request.
  - ACTIVE (`irq`=0, in-service=1, `irq_id` holds): on `reti_inst_detected`, go to IDLE. No nesting.
- `irq_ack` outside REQ and `reti_inst_detected` outside ACTIVE are ignored.
- A write to GIE takes effect in the FSM on the following cycle.

## Timing

- **Reset values.** `irq`=0, `irq_id`=0, FSM=IDLE, all registers 0, hence `cfg_rdata`=0 for any address.
- **Latency.** `irq_src` rises before edge E0 → sync1 at E0, sync2 at E1, PENDING set at E2, `irq`=1 after E3. Minimum source-to-request latency is 4 cycles when enabled and idle.
- `irq_ack` sampled in REQ → `irq`=0 from the next cycle. A new request needs at least reti, then one IDLE cycle.
- Reti in ACTIVE → IDLE next cycle; the next request is visible 1 cycle later (`irq` back-to-back gap ≥ 2 cycles after reti).
- **Simultaneous ack and new edge on the same source.** PENDING stays 1, and the source is re-requested after reti.
- **Asynchronous `rst` mid-handshake.** `irq` drops immediately and all pending events are lost.
- Writes take effect at the clock edge; `cfg_rdata` reflects the new value in the next cycle.

## Test plan

- **Basic handshake.** NUM_IRQ=8, ENABLE=0x04, GIE=1; pulse `irq_src[2]` → `irq`=1 with `irq_id`=2 four cycles later; `irq_ack` → PENDING=0, in-service=1; reti → IDLE, `irq` stays 0.
- **Priority.** ENABLE=0xFF; raise sources 5 and 3 in the same cycle → `irq_id`=3 first; after ack and reti → `irq_id`=5; PENDING ends at 0.
- **Masking and withdraw.**
  - Edge on source 1 with ENABLE=0 → PENDING=0x02, `irq`=0; set ENABLE[1] → request.
  - Clear GIE while in REQ → `irq`=0, PENDING[1] still 1.
- **Collision.**
  - `irq_ack` and a new rising edge of the same source reach PENDING in the same cycle → PENDING[id]=1 after ack.
  - A write-1-clear colliding with an edge → bit stays 1.
- **Reset.**
  - Assert `rst` asynchronously during REQ → `irq`=0 and `cfg_rdata`=0 without a clock edge.
  - Source held high through reset release → exactly one pending event.
- **Ignored strobes.** `irq_ack` in IDLE and reti in REQ have no effect; write 0xFFFFFFFF to ENABLE with NUM_IRQ=8 → reads 0x000000FF.
